inv_sub_bytes_seq: RTL and testbench
====================================

// Module: inv_sub_bytes_seq
// PURPOSE
// - AES decryption-side InvSubBytes engine: substitutes all 16 bytes of a 128-bit state
//   through the inverse S-box; it is the decrypt counterpart of the forward SubBytes/key S-box.
// - Sequential and area-reduced: LANES inverse S-box instances are time-shared over
//   16/LANES cycles. Valid/ready handshake on both sides.
// - Sits in the decrypt round datapath between InvShiftRows and AddRoundKey.
// PARAMETERS
// - LANES   4   bytes substituted per cycle; legal values 1, 2, 4, 8, 16 (elaboration error otherwise)
// PORTS
// - clk        input   1    single clock, rising edge
// - rst_n      input   1    asynchronous active-low reset
// - in_valid   input   1    in_state is valid
// - in_ready   output  1    engine can accept a state (IDLE only)
// - in_state   input   128  cipher state; byte 0 = [127:120] ... byte 15 = [7:0]
// - out_valid  output  1    out_state is valid; held until accepted
// - out_ready  input   1    downstream accepts out_state
// - out_state  output  128  InvSbox applied bytewise, same byte order as in_state
// - busy       output  1    high in SUB or DONE
// BEHAVIOUR
// - Reset (async, rst_n=0): FSM=IDLE; in_ready=1; out_valid=0; busy=0;
//   out_state=128'h0; byte counter=0.
// - FSM states: IDLE -> SUB -> DONE -> IDLE.
//   IDLE: in_ready=1. in_valid&&in_ready at an edge loads in_state into the state register,
//     clears the counter, and moves to SUB.
//   SUB: each cycle replaces bytes [k*LANES .. k*LANES+LANES-1] with InvSbox(byte), k = counter;
//     counter increments. After the cycle with k = 16/LANES-1, go to DONE.
//   DONE: out_valid=1, out_state = state register. out_valid&&out_ready -> IDLE.
// - Latency: out_valid rises exactly 16/LANES+1 edges after the accepting edge
//   (LANES=4: 5 edges). Throughput: one state per 16/LANES+2 cycles, no overlap.
// - in_ready=0 in SUB and DONE; in_valid in those states is ignored and not queued.
// - out_state is stable while out_valid=1 && out_ready=0; out_valid is never dropped
//   without a handshake.
// - A DONE handshake returns to IDLE; a new input is accepted no earlier than the next
//   edge (no same-cycle bypass).
// - Counter width = clog2(16/LANES), minimum 1. The counter is not used at LANES=16
//   (SUB lasts exactly one cycle).
// - rst_n asserted mid-SUB or mid-DONE: the partial state is discarded and all outputs
//   return to reset values asynchronously.
// - out_state = 0 except in DONE; no X propagation from an unloaded register.
// STRUCTURE
// - aes_pkg: STATE_BYTES=16, AES byte typedef, 256-entry INV_SBOX constant table.
//   The forward SBOX table also moves here so both directions share one package.
// - Sub-module inv_sbox: 8-bit combinational lookup of INV_SBOX, instantiated LANES times
//   via generate. Lane mux selects bytes by counter.
// - FSM + counter + 128-bit state register live in this module.
// TESTING
// - Reset then single state 637c777bf26b6fc53001672bfed7ab76 -> out_state
//   000102030405060708090a0b0c0d0e0f, out_valid at edge 5 after accept (LANES=4).
// - Bytewise spot values: in 00..00 -> 5252..52; in 16 repeated -> ff repeated;
//   in 63 repeated -> 00 repeated.
// - Backpressure: hold out_ready=0 for 7 cycles in DONE -> out_valid and out_state stable,
//   in_ready=0, a second in_valid is ignored; release -> one handshake, then IDLE.
// - Back-to-back: in_valid held high with two states -> second accepted exactly 2 cycles
//   after the first DONE handshake edge, both results correct, in order.
// - Async reset asserted during SUB (counter=2) -> out_valid=0, in_ready=1 immediately;
//   after release, a fresh state produces the correct result.
// - Sweep LANES in {1,2,4,8,16} on all 256 byte values (16 states) vs. a table model;
//   check latency 16/LANES+1 each time.

Source files
------------

// File: rtl/aes_pkg.sv
// AES shared definitions for the encrypt and decrypt datapaths.
// Holds the state geometry, the byte type, the InvSubBytes FSM encoding and
// both S-box tables so the forward and inverse directions come from one place.
package aes_pkg;

  localparam int STATE_BYTES = 16;
  localparam int STATE_BITS  = STATE_BYTES * 8;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } inv_sub_state_e;

  // Forward S-box (SubBytes / key schedule).
  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Inverse S-box (InvSubBytes).
  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sbox.sv
// Single-byte inverse S-box: purely combinational table lookup.
//   byte_i  input   8  byte to substitute
//   byte_o  output  8  INV_SBOX[byte_i]
module inv_sbox
  import aes_pkg::*;
(
  input  byte_t byte_i,
  output byte_t byte_o
);

  assign byte_o = INV_SBOX[byte_i];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes engine for the AES decrypt round.
// LANES inverse S-boxes are time-shared over 16/LANES SUB cycles; the state is
// loaded in IDLE, substituted in place during SUB and presented in DONE until
// the downstream handshake.
//   clk        input    1    rising-edge clock
//   rst_n      input    1    asynchronous active-low reset
//   in_valid   input    1    in_state is valid
//   in_ready   output   1    engine accepts a state (IDLE only)
//   in_state   input  128    cipher state, byte 0 = [127:120] .. byte 15 = [7:0]
//   out_valid  output   1    out_state valid, held until accepted
//   out_ready  input    1    downstream accepts out_state
//   out_state  output 128    substituted state, zero outside DONE
//   busy       output   1    high in SUB or DONE
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [STATE_BITS-1:0] in_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [STATE_BITS-1:0] out_state,
  output logic                  busy
);

  localparam int STEPS = STATE_BYTES / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  inv_sub_state_e        fsm_q, fsm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STATE_BITS-1:0] state_q, state_d;
  byte_t                 lane_in  [LANES];
  byte_t                 lane_out [LANES];
  logic                  last_step;

  assign last_step = (cnt_q == LAST_STEP);

  // Lane mux: lane j works on byte k*LANES+j, k = current step.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_in[j] = state_q[8*(STATE_BYTES-1-(int'(cnt_q)*LANES+j)) +: 8];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    inv_sbox u_inv_sbox (
      .byte_i (lane_in[j]),
      .byte_o (lane_out[j])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks, so every flop samples
      // the pre-edge values regardless of statement order.
      fsm_q <= fsm_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaulting every comb output first means no path leaves it
    // unassigned, so no latch is inferred.
    fsm_d = fsm_q;
    unique case (fsm_q)
      ST_IDLE: if (in_valid)  fsm_d = ST_SUB;
      ST_SUB:  if (last_step) fsm_d = ST_DONE;
      ST_DONE: if (out_ready) fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (fsm_q == ST_IDLE);
    out_valid = (fsm_q == ST_DONE);
    busy      = (fsm_q != ST_IDLE);
    out_state = (fsm_q == ST_DONE) ? state_q : '0;
  end

  // Datapath: load on accept, substitute one lane group per SUB cycle.
  // The counter wraps to zero on the last step so the lane mux index always
  // stays inside the state, including LANES=16 where it never leaves zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = in_state;
          cnt_d   = '0;
        end
      end
      ST_SUB: begin
        for (int j = 0; j < LANES; j++) begin
          state_d[8*(STATE_BYTES-1-(int'(cnt_q)*LANES+j)) +: 8] = lane_out[j];
        end
        cnt_d = last_step ? '0 : cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the state register is reset so an unloaded engine never shows X;
      // it is a flop bank, not a RAM, so the reset costs nothing structural.
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq. One instance per legal LANES
// value (instance g has LANES = 1<<g); directed tests run on LANES=4.
// The reference inverse S-box is derived from GF(2^8) arithmetic: inverse
// affine transform followed by the multiplicative inverse.
module tb_inv_sub_bytes_seq;

  localparam int NDUT = 5;
  localparam int G4   = 2;  // instance index of LANES=4

  logic         clk = 1'b0;
  logic         rst_n;
  logic [NDUT-1:0] in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [127:0] in_state_a  [NDUT];
  logic [127:0] out_state_a [NDUT];

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] inv_tbl [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inv_sub_bytes_seq #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_state  (in_state_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_state (out_state_a[g]),
      .busy      (busy_a[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] model_inv_sbox(input logic [7:0] b);
    logic [7:0] t = rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tbl[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rep_byte(input logic [7:0] b);
    return {16{b}};
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one state to instance g, wait for the result, check value and
  // latency, then complete the output handshake.  Latency is counted in edges
  // with the accepting edge as edge 1, so with an immediate handshake the
  // accept-to-accept period is that count plus one (16/LANES+2).
  task automatic run_one(input int g, input logic [127:0] s, input string tag);
    int n = 16 / (1 << g);
    int lat = 0;
    logic [127:0] exp = ref_state(s);
    in_state_a[g] = s;
    in_valid_a[g] = 1'b1;
    while (!in_ready_a[g] && lat < 50) begin
      step();
      lat++;
    end
    check({tag, ".ready"}, 128'(in_ready_a[g]), 128'(1));
    step();
    in_valid_a[g] = 1'b0;
    check({tag, ".busy"}, 128'(busy_a[g]), 128'(1));
    lat = 1;
    while (!out_valid_a[g] && lat < 100) begin
      step();
      lat++;
    end
    check({tag, ".lat"}, 128'(lat), 128'(n + 1));
    check({tag, ".data"}, out_state_a[g], exp);
    out_ready_a[g] = 1'b1;
    step();
    out_ready_a[g] = 1'b0;
    check({tag, ".idle"}, 128'({in_ready_a[g], out_valid_a[g], busy_a[g]}), 128'(3'b100));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] s1, s2, exp1;
    logic [127:0] got_q [$];
    int acc_edge [$];
    int edge_no;
    int perm [256];

    rst_n       = 1'b0;
    in_valid_a  = '0;
    out_ready_a = '0;
    for (int g = 0; g < NDUT; g++) in_state_a[g] = '0;
    for (int i = 0; i < 256; i++) inv_tbl[i] = model_inv_sbox(8'(i));

    // Reset state on every instance
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("reset.ctl%0d", g),
            128'({in_ready_a[g], out_valid_a[g], busy_a[g]}), 128'(3'b100));
      check($sformatf("reset.out%0d", g), out_state_a[g], 128'h0);
    end
    rst_n = 1'b1;
    step();

    // Known vector: forward S-box outputs for 00..0f
    run_one(G4, 128'h637c777bf26b6fc53001672bfed7ab76, "kat");
    // Model sanity against the published relation, independent of the DUT
    check("kat.model", ref_state(128'h637c777bf26b6fc53001672bfed7ab76),
          128'h000102030405060708090a0b0c0d0e0f);

    // Bytewise spot values
    check("spot00.model", ref_state(rep_byte(8'h00)), rep_byte(8'h52));
    check("spot16.model", ref_state(rep_byte(8'h16)), rep_byte(8'hff));
    check("spot63.model", ref_state(rep_byte(8'h63)), rep_byte(8'h00));
    run_one(G4, rep_byte(8'h00), "spot00");
    run_one(G4, rep_byte(8'h16), "spot16");
    run_one(G4, rep_byte(8'h63), "spot63");

    // Random states on LANES=4
    for (int t = 0; t < 8; t++) begin
      run_one(G4, {$urandom, $urandom, $urandom, $urandom}, $sformatf("rand%0d", t));
    end

    // Backpressure: hold out_ready low 7 cycles in DONE, offer a second state
    s1   = {$urandom, $urandom, $urandom, $urandom};
    s2   = ~s1;
    exp1 = ref_state(s1);
    in_state_a[G4] = s1;
    in_valid_a[G4] = 1'b1;
    check("bp.ready", 128'(in_ready_a[G4]), 128'(1));
    step();
    in_valid_a[G4] = 1'b0;
    for (int i = 0; i < 100 && !out_valid_a[G4]; i++) step();
    in_state_a[G4] = s2;
    in_valid_a[G4] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("bp.valid%0d", i), 128'(out_valid_a[G4]), 128'(1));
      check($sformatf("bp.data%0d", i), out_state_a[G4], exp1);
      check($sformatf("bp.inrdy%0d", i), 128'(in_ready_a[G4]), 128'(0));
      step();
    end
    in_valid_a[G4]  = 1'b0;
    out_ready_a[G4] = 1'b1;
    check("bp.rel.data", out_state_a[G4], exp1);
    step();
    out_ready_a[G4] = 1'b0;
    check("bp.after", 128'({in_ready_a[G4], out_valid_a[G4], busy_a[G4]}), 128'(3'b100));
    step();
    check("bp.notqueued", 128'({in_ready_a[G4], busy_a[G4]}), 128'(2'b10));

    // Back-to-back with in_valid held high and out_ready high
    s1 = {$urandom, $urandom, $urandom, $urandom};
    s2 = {$urandom, $urandom, $urandom, $urandom};
    in_state_a[G4]  = s1;
    in_valid_a[G4]  = 1'b1;
    out_ready_a[G4] = 1'b1;
    edge_no = 0;
    while (got_q.size() < 2 && edge_no < 60) begin
      logic acc, hs;
      acc = in_valid_a[G4] && in_ready_a[G4];
      hs  = out_valid_a[G4] && out_ready_a[G4];
      if (hs) got_q.push_back(out_state_a[G4]);
      step();
      edge_no++;
      if (acc) begin
        acc_edge.push_back(edge_no);
        if (acc_edge.size() == 1) in_state_a[G4] = s2;
        else in_valid_a[G4] = 1'b0;
      end
    end
    in_valid_a[G4]  = 1'b0;
    out_ready_a[G4] = 1'b0;
    check("b2b.count", 128'(got_q.size()), 128'(2));
    if (got_q.size() == 2) begin
      check("b2b.first", got_q[0], ref_state(s1));
      check("b2b.second", got_q[1], ref_state(s2));
    end
    check("b2b.naccept", 128'(acc_edge.size()), 128'(2));
    if (acc_edge.size() == 2) begin
      check("b2b.spacing", 128'(acc_edge[1] - acc_edge[0]), 128'(4 + 2));
    end
    step();

    // Async reset in SUB at counter=2
    in_state_a[G4] = {$urandom, $urandom, $urandom, $urandom};
    in_valid_a[G4] = 1'b1;
    step();
    in_valid_a[G4] = 1'b0;
    step();
    step();
    check("arst.pre", 128'(busy_a[G4]), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst.ctl", 128'({in_ready_a[G4], out_valid_a[G4], busy_a[G4]}), 128'(3'b100));
    check("arst.out", out_state_a[G4], 128'h0);
    #1 rst_n = 1'b1;
    step();
    run_one(G4, {$urandom, $urandom, $urandom, $urandom}, "arst.fresh");

    // Sweep every LANES on all 256 byte values (shuffled into 16 states)
    for (int g = 0; g < NDUT; g++) begin
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
        int j = int'($urandom_range(i, 0));
        int tmp = perm[i];
        perm[i] = perm[j];
        perm[j] = tmp;
      end
      for (int k = 0; k < 16; k++) begin
        logic [127:0] s;
        for (int b = 0; b < 16; b++) s[8*(15-b) +: 8] = 8'(perm[16*k + b]);
        run_one(g, s, $sformatf("sweep.l%0d.s%0d", 1 << g, k));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
